seq_multiplier: RTL and testbench
=================================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have ports: Clk  input  1  single clock; all state changes on posedge.
REQ-002 SHALL have ports: Reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: Start  input  1  request to begin an operation; sampled on posedge.
REQ-004 SHALL have ports: Op  input  2  00=MUL (low 64 of product), 01=UMULH (high 64, unsigned), 10=SMULH (high 64, signed), 11=treated as MUL.
REQ-005 SHALL have ports: BusA  input  64  multiplicand, driven from register-file read port A.
REQ-006 SHALL have ports: BusB  input  64  multiplier, driven from register-file read port B.
REQ-007 SHALL have ports: Busy  output  1  operation in progress; Start ignored while high.
REQ-008 SHALL have ports: Done  output  1  one-cycle pulse: Result newly valid.
REQ-009 SHALL have ports: Result  output  64  registered result, destined for register-file write bus BusW.
REQ-010 SHALL have parameter: WIDTH, default 64, operand width; all widths above scale with it.

Function
REQ-011 SHALL implement states IDLE, RUN, FIX, DONE.
REQ-012 SHALL accept Start only in IDLE or DONE (Busy=0): on the accept edge it latches BusA, BusB and Op, clears the 128-bit accumulator, loads iteration counter 0, and enters RUN.
REQ-013 SHALL, for SMULH, latch |BusA| and |BusB| and record sign = BusA[63] XOR BusB[63]; for MUL/UMULH, operands are latched unmodified.
REQ-014 SHALL perform one radix-2 shift-add iteration per posedge in RUN, 64 iterations exactly; counter increments 0..63 and wraps to 0 on leaving RUN.
REQ-015 SHALL move RUN->FIX on the 64th RUN edge; in FIX, apply two's-complement negation of the 128-bit product when SMULH and sign=1, load Result with the Op-selected half, and move to DONE.
REQ-016 SHALL hold Done=1 for exactly the one cycle spent in DONE, then return to IDLE unless a Start is accepted in DONE (then enter RUN directly, Done still a single pulse).
REQ-017 SHALL drive Busy=1 in RUN and FIX only.
REQ-018 SHALL give fixed latency: accept at edge E0, Result and Done valid after edge E65, independent of operand values (no early termination).
REQ-019 SHALL hold Result stable from FIX load until the next FIX load; accepting a new Start SHALL NOT clear Result.
REQ-020 SHALL ignore changes on BusA, BusB and Op after the accept edge.
REQ-021 SHALL ignore Start while Busy=1; no queuing, no error flag.
REQ-022 SHALL compute the most-negative SMULH operand (0x8000_0000_0000_0000) correctly: its magnitude 2^63 SHALL be held without overflow in the unsigned operand register.
REQ-023 SHALL produce all arithmetic modulo 2^128 internally; MUL result equals low 64 bits regardless of signedness.

Reset
REQ-024 SHALL, while Reset=1, force state IDLE, Busy=0, Done=0, Result=0, counter=0, accumulator=0, independent of Clk.
REQ-025 SHALL abort any operation in progress on Reset with no Done pulse; the first edge after Reset deasserts behaves as IDLE.

Verification
REQ-026 SHALL pass: Op=00, BusA=3, BusB=5, Start pulse -> Busy high 65 cycles, Done pulse after E65, Result=0x000000000000000F.
REQ-027 SHALL pass: Op=01, BusA=BusB=0xFFFFFFFFFFFFFFFF -> Result=0xFFFFFFFFFFFFFFFE; same operands Op=00 -> Result=0x0000000000000001.
REQ-028 SHALL pass: Op=10, BusA=0xFFFFFFFFFFFFFFFE (-2), BusB=3 -> Result=0xFFFFFFFFFFFFFFFF; BusA=BusB=0x8000000000000000 -> Result=0x4000000000000000.
REQ-029 SHALL pass: Start re-asserted with different operands at E10 during RUN -> ignored; original result delivered after E65.
REQ-030 SHALL pass: Reset asserted mid-RUN (between E30 and E31) -> Busy=0, Done=0, Result=0 immediately; no Done pulse follows; next Start completes normally.
REQ-031 SHALL pass: Start held high in DONE cycle with BusA=7, BusB=6, Op=00 -> back-to-back accept, single Done pulse per operation, second Result=0x000000000000002A.

Source files
------------

// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
//
// Iterative radix-2 shift-add multiplier for a 64-bit datapath. One operation
// multiplies BusA by BusB and returns either the low or the high half of the
// 2*WIDTH-bit product:
//   Op = 00 / 11 : MUL    low  WIDTH bits of the product
//   Op = 01      : UMULH  high WIDTH bits, operands unsigned
//   Op = 10      : SMULH  high WIDTH bits, operands signed
//
// The latency is fixed. Start is accepted at edge E0. WIDTH shift-add
// iterations follow, then one fix-up cycle that applies the sign. Result and
// Done are valid after edge E0 + WIDTH + 1. There is no early termination.
//
// Ports
//   Clk     in   1      single clock; all state changes on posedge
//   Reset   in   1      asynchronous, active-high reset
//   Start   in   1      begin an operation (ignored while Busy)
//   Op      in   2      operation select (see above)
//   BusA    in   WIDTH  multiplicand (register-file read port A)
//   BusB    in   WIDTH  multiplier   (register-file read port B)
//   Busy    out  1      high in RUN and FIX
//   Done    out  1      one-cycle pulse while in DONE; Result newly valid
//   Result  out  WIDTH  registered result, held until the next FIX load
//
// WIDTH must be at least 2.
// -----------------------------------------------------------------------------
module seq_multiplier #(
    parameter int WIDTH = 64
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] BusA,
    input  logic [WIDTH-1:0] BusB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result
);

    localparam int CW = $clog2(WIDTH);
    localparam int PW = 2 * WIDTH;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_UMULH = 2'b01;
    localparam logic [1:0] OP_SMULH = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_next;

    // Control decoded by the FSM.
    logic accept;     // Start taken this edge
    logic last_iter;  // current RUN edge is the final iteration

    // Datapath state.
    logic [CW-1:0]    cnt;      // iteration counter, 0..WIDTH-1
    logic [PW-1:0]    acc;      // running product, modulo 2^PW
    logic [PW-1:0]    mcand;    // multiplicand, shifted left once per iteration
    logic [WIDTH-1:0] mplier;   // multiplier, shifted right once per iteration
    logic [1:0]       op_q;     // operation latched at accept
    logic             neg_q;    // SMULH result must be negated in FIX

    // Operand preparation at accept time.
    logic             is_smulh;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;

    // Fix-up stage.
    logic [PW-1:0]    product;
    logic [WIDTH-1:0] result_sel;

    assign last_iter = (cnt == CW'(WIDTH - 1));

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments, so every always_ff
    // block samples the pre-edge value of every other register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and output decode
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first. A path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;

        unique case (state)
            IDLE: begin
                if (Start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end

            RUN: begin
                Busy = 1'b1;
                if (last_iter) begin
                    state_next = FIX;
                end
            end

            FIX: begin
                Busy       = 1'b1;
                state_next = DONE;
            end

            DONE: begin
                // Done marks the DONE cycle only. A back-to-back Start goes
                // straight to RUN, so the pulse stays one cycle wide.
                Done = 1'b1;
                if (Start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Operand preparation
    // -------------------------------------------------------------------------
    // SMULH multiplies magnitudes and restores the sign in FIX. Because
    // mag_a/mag_b are unsigned WIDTH-bit values, the most-negative input
    // (only the MSB set) negates to itself and reads correctly as 2^(WIDTH-1).
    assign is_smulh = (Op == OP_SMULH);
    assign a_neg    = is_smulh & BusA[WIDTH-1];
    assign b_neg    = is_smulh & BusB[WIDTH-1];
    assign mag_a    = a_neg ? -BusA : BusA;
    assign mag_b    = b_neg ? -BusB : BusB;

    // -------------------------------------------------------------------------
    // Fix-up: apply the sign and pick the requested half
    // -------------------------------------------------------------------------
    assign product = neg_q ? -acc : acc;

    always_comb begin
        result_sel = product[WIDTH-1:0];
        case (op_q)
            OP_UMULH,
            OP_SMULH: result_sel = product[PW-1:WIDTH];
            default:  result_sel = product[WIDTH-1:0];  // MUL and 11
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            op_q   <= OP_MUL;
            neg_q  <= 1'b0;
            Result <= '0;
        end else if (accept) begin
            // Result is deliberately left alone. It keeps the previous answer
            // until the next FIX load.
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            op_q   <= Op;
            neg_q  <= is_smulh & (BusA[WIDTH-1] ^ BusB[WIDTH-1]);
        end else if (state == RUN) begin
            // Adding the shifted multiplicand for each set multiplier bit
            // (LSB first) produces the full product after WIDTH steps.
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= last_iter ? '0 : cnt + CW'(1);
        end else if (state == FIX) begin
            Result <= result_sel;
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// -----------------------------------------------------------------------------
// tb_seq_multiplier
//
// Directed bench for seq_multiplier. Expected results go into a queue when an
// operation is started. They are popped and compared when Done is seen.
// Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_seq_multiplier;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [1:0]  Op;
    logic [63:0] BusA;
    logic [63:0] BusB;
    logic        Busy;
    logic        Done;
    logic [63:0] Result;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_q[$];

    always #5 Clk = ~Clk;

    seq_multiplier #(.WIDTH(64)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Start  (Start),
        .Op     (Op),
        .BusA   (BusA),
        .BusB   (BusB),
        .Busy   (Busy),
        .Done   (Done),
        .Result (Result)
    );

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference model: a direct 128-bit multiply, signed via sign extension.
    function automatic logic [63:0] model(input logic [1:0] op,
                                          input logic [63:0] a,
                                          input logic [63:0] b);
        logic [127:0] u;
        logic [127:0] s;
        u = {64'b0, a} * {64'b0, b};
        s = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
        case (op)
            2'b01:   return u[127:64];
            2'b10:   return s[127:64];
            default: return u[63:0];
        endcase
    endfunction

    // Drive one accepted Start (caller is in IDLE or DONE). The operand buses
    // are scrambled right after the accept edge.
    task automatic start_op(input logic [1:0] op, input logic [63:0] a,
                            input logic [63:0] b, input logic [63:0] expected);
        Op    = op;
        BusA  = a;
        BusB  = b;
        Start = 1'b1;
        exp_q.push_back(expected);
        tick();
        Start = 1'b0;
        Op    = 2'($urandom);
        BusA  = {$urandom, $urandom};
        BusB  = {$urandom, $urandom};
    endtask

    // Wait for Done. Check latency, the Busy duration and the result.
    // When poke >= 0, a Start with different operands is driven so that it
    // is sampled at edge E(poke+1).
    task automatic run_op(input string tag, input int poke);
        int          n        = 0;
        int          busy_cnt = 0;
        logic [63:0] expected;
        while (Done !== 1'b1 && n < 200) begin
            if (Busy === 1'b1) busy_cnt++;
            if (n == poke) begin
                Start = 1'b1;
                Op    = 2'b00;
                BusA  = 64'h0000_0000_0000_1234;
                BusB  = 64'h0000_0000_0000_0099;
            end else begin
                Start = 1'b0;
            end
            tick();
            n++;
        end
        Start = 1'b0;
        check({tag, "_done_seen"}, 64'(Done), 64'd1);
        check({tag, "_latency"}, 64'(n), 64'd65);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd65);
        check({tag, "_busy_in_done"}, 64'(Busy), 64'd0);
        if (exp_q.size() != 0) expected = exp_q.pop_front();
        else                   expected = 'x;
        check({tag, "_result"}, Result, expected);
    endtask

    // Leave DONE without a new Start. Done must fall after a single cycle.
    task automatic finish_idle(input string tag);
        tick();
        check({tag, "_done_pulse_end"}, 64'(Done), 64'd0);
        check({tag, "_idle_busy"}, 64'(Busy), 64'd0);
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  op;
        int          done_cnt;
        logic [63:0] held;

        Reset = 1'b1;
        Start = 1'b0;
        Op    = 2'b00;
        BusA  = '0;
        BusB  = '0;

        // Reset state, checked before any clock edge.
        #2;
        check("reset_busy", 64'(Busy), 64'd0);
        check("reset_done", 64'(Done), 64'd0);
        check("reset_result", Result, 64'd0);
        tick();
        tick();
        Reset = 1'b0;
        tick();

        // Basic MUL.
        start_op(2'b00, 64'd3, 64'd5, 64'h0000_0000_0000_000F);
        run_op("mul_3x5", -1);
        finish_idle("mul_3x5");

        // UMULH and MUL of all-ones operands.
        start_op(2'b01, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("umulh_ones", -1);
        finish_idle("umulh_ones");
        start_op(2'b00, '1, '1, 64'h0000_0000_0000_0001);
        run_op("mul_ones", -1);
        finish_idle("mul_ones");

        // SMULH with a negative operand, then the most-negative operand.
        start_op(2'b10, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("smulh_m2x3", -1);
        finish_idle("smulh_m2x3");
        start_op(2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                 64'h4000_0000_0000_0000);
        run_op("smulh_minneg", -1);
        finish_idle("smulh_minneg");

        // A Start sampled at E10 during RUN is ignored.
        start_op(2'b00, 64'h0000_0001_0000_0003, 64'h0000_0000_0000_0011,
                 model(2'b00, 64'h0000_0001_0000_0003, 64'h0000_0000_0000_0011));
        run_op("ignore_start", 9);
        finish_idle("ignore_start");

        // Model-checked operations across all four Op codes.
        for (int i = 0; i < 4; i++) begin
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            op = 2'(i);
            start_op(op, a, b, model(op, a, b));
            run_op($sformatf("rand_op%0d", i), -1);
            finish_idle($sformatf("rand_op%0d", i));
        end

        // Reset between E30 and E31 aborts the operation at once.
        held = Result;
        start_op(2'b10, 64'hFFFF_FFFF_FFFF_FFF9, 64'd11,
                 model(2'b10, 64'hFFFF_FFFF_FFFF_FFF9, 64'd11));
        for (int i = 0; i < 30; i++) tick();
        check("midrun_busy_before", 64'(Busy), 64'd1);
        check("midrun_result_held", Result, held);
        #2;
        Reset = 1'b1;
        #1;
        check("midrun_reset_busy", 64'(Busy), 64'd0);
        check("midrun_reset_done", 64'(Done), 64'd0);
        check("midrun_reset_result", Result, 64'd0);
        void'(exp_q.pop_front());
        tick();
        Reset    = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            if (Done === 1'b1) done_cnt++;
            tick();
        end
        check("midrun_no_done", 64'(done_cnt), 64'd0);
        check("midrun_idle_busy", 64'(Busy), 64'd0);
        start_op(2'b01, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                 model(2'b01, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210));
        run_op("after_reset", -1);
        finish_idle("after_reset");

        // Back-to-back: Start held during the DONE cycle.
        start_op(2'b00, 64'd9, 64'd9, 64'd81);
        run_op("b2b_first", -1);
        start_op(2'b00, 64'd7, 64'd6, 64'h0000_0000_0000_002A);
        check("b2b_done_single", 64'(Done), 64'd0);
        check("b2b_busy_again", 64'(Busy), 64'd1);
        check("b2b_result_kept", Result, 64'd81);
        run_op("b2b_second", -1);
        finish_idle("b2b_second");

        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net: the bench must end on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
